// File: rtl/mandelbrot_stream.sv
// Streaming Mandelbrot/Julia escape-time engine: iterates one pixel at a time in
// raster order and delivers iteration counts over a valid/ready pixel stream.
module mandelbrot_stream #(
    parameter  int BITWIDTH = 10,
    parameter  int FRAC     = BITWIDTH - 3,
    parameter  int CTRWIDTH = 8,
    parameter  int MAXW     = 320,
    parameter  int MAXH     = 240,
    localparam int XW       = $clog2(MAXW + 1),
    localparam int YW       = $clog2(MAXH + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic                julia,
    input  logic [XW-1:0]       cfg_width,
    input  logic [YW-1:0]       cfg_height,
    input  logic [CTRWIDTH-1:0] max_ctr,
    input  logic [6:0]          scaling,
    input  logic [BITWIDTH-1:0] cr_offset,
    input  logic [BITWIDTH-1:0] ci_offset,
    input  logic [BITWIDTH-1:0] julia_cr,
    input  logic [BITWIDTH-1:0] julia_ci,
    output logic                busy,
    output logic                pix_valid,
    input  logic                pix_ready,
    output logic [CTRWIDTH-1:0] pix_ctr,
    output logic [XW-1:0]       pix_x,
    output logic [YW-1:0]       pix_y,
    output logic                pix_eol,
    output logic                pix_last,
    output logic                frame_done
);
    localparam int PW = 2 * BITWIDTH + 2;
    localparam logic signed [PW-1:0] FOUR = PW'(64'd4 << (2 * FRAC));

    typedef enum logic {IDLE, ITER} state_t;
    state_t state, state_nx;

    logic [XW-1:0]       last_x, x, nx_x;
    logic [YW-1:0]       last_y, y, nx_y;
    logic [CTRWIDTH-1:0] max_q, ctr;
    logic [BITWIDTH-1:0] step_q, cr_off_q, jcr_q, jci_q;
    logic                julia_q, ovf;
    logic [BITWIDTH-1:0] p_re, p_im, nx_re, nx_im;
    logic signed [BITWIDTH-1:0] zr, zi, cr, ci;

    logic signed [PW-1:0] zr_w, zi_w, zr2, zi2, zrzi, new_r, new_i;
    logic ovf_nx, brk, at_eol, is_last, slot_free;
    logic do_start, do_iter, do_emit;
    logic                ld_julia;
    logic [BITWIDTH-1:0] ld_re, ld_im, ld_jcr, ld_jci;

    // One escape-time step at full precision; the stored z is the truncated result.
    always_comb begin
        zr_w   = PW'(zr);
        zi_w   = PW'(zi);
        zr2    = zr_w * zr_w;
        zi2    = zi_w * zi_w;
        zrzi   = zr_w * zi_w;
        new_r  = ((zr2 - zi2) >>> FRAC) + PW'(cr);
        new_i  = ((zrzi <<< 1) >>> FRAC) + PW'(ci);
        ovf_nx = (new_r != PW'($signed(new_r[BITWIDTH-1:0])))
              || (new_i != PW'($signed(new_i[BITWIDTH-1:0])));
        brk    = ((zr2 + zi2) >= FOUR) || (ctr == max_q) || ovf;
    end

    assign at_eol     = (x == last_x);
    assign is_last    = at_eol && (y == last_y);
    assign slot_free  = !pix_valid || pix_ready;
    assign busy       = (state == ITER);
    assign frame_done = pix_valid && pix_ready && pix_last;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no latch is inferred.
        state_nx = state;
        do_start = 1'b0;
        do_iter  = 1'b0;
        do_emit  = 1'b0;
        case (state)
            IDLE: if (start && !abort) begin
                do_start = 1'b1;
                state_nx = ITER;
            end
            ITER: begin
                if (abort) begin
                    state_nx = IDLE;
                end else if (!brk) begin
                    do_iter = 1'b1;
                end else if (slot_free) begin
                    do_emit = 1'b1;
                    if (is_last) state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Next raster position; the coordinate is stepped incrementally, wrapping mod 2^BITWIDTH.
    always_comb begin
        if (at_eol) begin
            nx_x  = '0;
            nx_y  = y + YW'(1);
            nx_re = cr_off_q;
            nx_im = p_im + step_q;
        end else begin
            nx_x  = x + XW'(1);
            nx_y  = y;
            nx_re = p_re + step_q;
            nx_im = p_im;
        end
        ld_re    = do_start ? cr_offset : nx_re;
        ld_im    = do_start ? ci_offset : nx_im;
        ld_julia = do_start ? julia     : julia_q;
        ld_jcr   = do_start ? julia_cr  : jcr_q;
        ld_jci   = do_start ? julia_ci  : jci_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_x   <= '0;
            last_y   <= '0;
            max_q    <= '0;
            step_q   <= '0;
            cr_off_q <= '0;
            jcr_q    <= '0;
            jci_q    <= '0;
            julia_q  <= 1'b0;
        end else if (do_start) begin
            last_x   <= (cfg_width == '0) ? '0 : cfg_width - XW'(1);
            last_y   <= (cfg_height == '0) ? '0 : cfg_height - YW'(1);
            max_q    <= max_ctr;
            step_q   <= BITWIDTH'({1'b0, scaling} + 8'd1);
            cr_off_q <= cr_offset;
            jcr_q    <= julia_cr;
            jci_q    <= julia_ci;
            julia_q  <= julia;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x    <= '0;
            y    <= '0;
            p_re <= '0;
            p_im <= '0;
            zr   <= '0;
            zi   <= '0;
            cr   <= '0;
            ci   <= '0;
            ctr  <= '0;
            ovf  <= 1'b0;
        end else if (do_start || do_emit) begin
            x    <= do_start ? '0 : nx_x;
            y    <= do_start ? '0 : nx_y;
            p_re <= ld_re;
            p_im <= ld_im;
            zr   <= ld_julia ? ld_re : '0;
            zi   <= ld_julia ? ld_im : '0;
            cr   <= ld_julia ? ld_jcr : ld_re;
            ci   <= ld_julia ? ld_jci : ld_im;
            ctr  <= '0;
            ovf  <= 1'b0;
        end else if (do_iter) begin
            zr   <= new_r[BITWIDTH-1:0];
            zi   <= new_i[BITWIDTH-1:0];
            ctr  <= ctr + CTRWIDTH'(1);
            ovf  <= ovf_nx;
        end
    end

    // A beat is held until accepted; abort drops it, a new break may replace it on the handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_valid <= 1'b0;
            pix_ctr   <= '0;
            pix_x     <= '0;
            pix_y     <= '0;
            pix_eol   <= 1'b0;
            pix_last  <= 1'b0;
        end else if (state == ITER && abort) begin
            pix_valid <= 1'b0;
        end else if (do_emit) begin
            pix_valid <= 1'b1;
            pix_ctr   <= ctr;
            pix_x     <= x;
            pix_y     <= y;
            pix_eol   <= at_eol;
            pix_last  <= is_last;
        end else if (pix_ready) begin
            pix_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mandelbrot_stream.sv
// Randomised self-checking bench for mandelbrot_stream with an arithmetic escape-time
// model and a raster-order expected-beat queue per frame.
module tb_mandelbrot_stream;
    localparam int CW  = 8;
    localparam int XW  = 9;
    localparam int YW  = 8;
    localparam int ESC = 4 << 14;

    typedef struct packed {
        int ctr;
        int x;
        int y;
        bit eol;
        bit last;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst, start, abort, julia, pix_ready;
    logic [XW-1:0] cfg_width;
    logic [YW-1:0] cfg_height;
    logic [CW-1:0] max_ctr;
    logic [6:0]    scaling;
    logic [9:0]    cr_offset, ci_offset, julia_cr, julia_ci;
    logic          busy, pix_valid, pix_eol, pix_last, frame_done;
    logic [CW-1:0] pix_ctr;
    logic [XW-1:0] pix_x;
    logic [YW-1:0] pix_y;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mandelbrot_stream dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .julia(julia),
        .cfg_width(cfg_width), .cfg_height(cfg_height), .max_ctr(max_ctr),
        .scaling(scaling), .cr_offset(cr_offset), .ci_offset(ci_offset),
        .julia_cr(julia_cr), .julia_ci(julia_ci), .busy(busy),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_ctr(pix_ctr),
        .pix_x(pix_x), .pix_y(pix_y), .pix_eol(pix_eol), .pix_last(pix_last),
        .frame_done(frame_done)
    );

    function automatic int wrap10(input int v);
        int t;
        t = v & 1023;
        if (t >= 512) t -= 1024;
        return t;
    endfunction

    // Escape-time count for one pixel in 10-bit Q3.7 arithmetic.
    function automatic int ref_iter(input int c_re, c_im, z_re0, z_im0, mx);
        int zr, zi, k, nr, ni;
        bit ovf;
        zr = z_re0; zi = z_im0; k = 0; ovf = 1'b0;
        while (1) begin
            if (zr * zr + zi * zi >= ESC || k == mx || ovf) return k;
            nr  = ((zr * zr - zi * zi) >>> 7) + c_re;
            ni  = ((2 * zr * zi) >>> 7) + c_im;
            ovf = (nr < -512 || nr > 511 || ni < -512 || ni > 511);
            zr  = wrap10(nr);
            zi  = wrap10(ni);
            k++;
        end
    endfunction

    task automatic set_cfg(input int w, h, mx, sc, cro, cio, input bit jul, input int jcr, jci);
        cfg_width  = w[XW-1:0];
        cfg_height = h[YW-1:0];
        max_ctr    = mx[CW-1:0];
        scaling    = sc[6:0];
        cr_offset  = cro[9:0];
        ci_offset  = cio[9:0];
        julia      = jul;
        julia_cr   = jcr[9:0];
        julia_ci   = jci[9:0];
    endtask

    task automatic scramble_cfg();
        set_cfg($urandom_range(0, 320), $urandom_range(0, 240), $urandom_range(0, 255),
                $urandom_range(0, 127), $urandom_range(0, 1023), $urandom_range(0, 1023),
                1'($urandom_range(0, 1)), $urandom_range(0, 1023), $urandom_range(0, 1023));
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; abort = 1'b0; pix_ready = 1'b0;
        set_cfg(1, 1, 0, 0, 0, 0, 1'b0, 0, 0);
        #1 rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset busy: got %b want 0", busy); end
        checks++; if (pix_valid !== 1'b0)  begin errors++; $display("FAIL reset pix_valid: got %b want 0", pix_valid); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset frame_done: got %b want 0", frame_done); end
        checks++; if (pix_ctr !== '0)      begin errors++; $display("FAIL reset pix_ctr: got %0d want 0", pix_ctr); end
        checks++; if (pix_x !== '0 || pix_y !== '0) begin errors++; $display("FAIL reset pix_xy: got %0d,%0d want 0,0", pix_x, pix_y); end
        checks++; if (pix_eol !== 1'b0 || pix_last !== 1'b0) begin errors++; $display("FAIL reset eol_last: got %b%b want 00", pix_eol, pix_last); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_small_frame();
        int ex, ey;
        bit eeol, elast;
        set_cfg(2, 2, 0, 0, 0, 0, 1'b0, 0, 0);
        pix_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || pix_valid !== 1'b0) begin
            errors++; $display("FAIL small first_cycle: busy=%b valid=%b want busy=1 valid=0", busy, pix_valid);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            ex = i % 2; ey = i / 2; eeol = (ex == 1); elast = (i == 3);
            checks++;
            if (pix_valid !== 1'b1 || pix_x !== XW'(ex) || pix_y !== YW'(ey) || pix_ctr !== '0 ||
                pix_eol !== eeol || pix_last !== elast || frame_done !== elast) begin
                errors++;
                $display("FAIL small beat%0d: valid=%b x=%0d y=%0d ctr=%0d eol=%b last=%b done=%b want 1 %0d %0d 0 %b %b %b",
                         i, pix_valid, pix_x, pix_y, pix_ctr, pix_eol, pix_last, frame_done, ex, ey, eeol, elast, elast);
            end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL small busy_drop: got %b want 0", busy); end
        @(negedge clk);
        checks++; if (pix_valid !== 1'b0) begin errors++; $display("FAIL small valid_clear: got %b want 0", pix_valid); end
    endtask

    // Single 1x1 frame: checks count, ITER-cycle latency and end-of-frame flags.
    task automatic run_single(input string name, input int pre, pim, input bit jul,
                              input int jcr, jci, mx, exp_ctr);
        int iters;
        bit seen;
        set_cfg(1, 1, mx, 0, pre, pim, jul, jcr, jci);
        pix_ready = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        iters = 0; seen = 1'b0;
        for (int cyc = 0; cyc < 400 && !seen; cyc++) begin
            if (pix_valid === 1'b1) seen = 1'b1;
            else begin
                if (busy === 1'b1) iters++;
                @(negedge clk);
            end
        end
        checks++; if (!seen) begin errors++; $display("FAIL %s timeout: got no beat want one", name); end
        checks++;
        if ($isunknown({pix_ctr, pix_x, pix_y, pix_eol, pix_last}) || pix_ctr !== CW'(exp_ctr)) begin
            errors++; $display("FAIL %s ctr: got %0d want %0d", name, pix_ctr, exp_ctr);
        end
        checks++; if (iters != exp_ctr + 1) begin errors++; $display("FAIL %s latency: got %0d want %0d", name, iters, exp_ctr + 1); end
        checks++; if (pix_last !== 1'b1 || pix_eol !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL %s flags: last=%b eol=%b busy=%b want 1 1 0", name, pix_last, pix_eol, busy);
        end
        pix_ready = 1'b1;
        #1;
        checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL %s frame_done: got %b want 1", name, frame_done); end
        @(negedge clk);
        pix_ready = 1'b0;
        checks++; if (pix_valid !== 1'b0) begin errors++; $display("FAIL %s drain: valid=%b want 0", name, pix_valid); end
    endtask

    task automatic test_center();
        run_single("center", 0, 0, 1'b0, 0, 0, 20, 20);
    endtask

    task automatic test_escape();
        run_single("escape_mandel", 256, 0, 1'b0, 0, 0, 50, 1);
        run_single("escape_julia", 256, 0, 1'b1, 0, 0, 50, 0);
    endtask

    task automatic test_overflow();
        run_single("ovf_big_c", 499, 499, 1'b0, 0, 0, 50, 1);
        // z wraps to a small value; only the overflow flag stops the iteration.
        run_single("ovf_flag", 255, 0, 1'b1, 511, 0, 50, 1);
    endtask

    task automatic run_frame(input string name, input int w, h, mx, sc, cro, cio,
                             input bit jul, input int jcr, jci, ready_pct);
        beat_t exq[$];
        beat_t b;
        int ew, eh, n, got, budget, pr, pm;
        bit held;
        logic [CW-1:0] h_ctr;
        logic [XW-1:0] h_x;
        logic [YW-1:0] h_y;
        logic h_eol, h_last;
        ew = (w == 0) ? 1 : w;
        eh = (h == 0) ? 1 : h;
        for (int yy = 0; yy < eh; yy++) begin
            for (int xx = 0; xx < ew; xx++) begin
                pr = wrap10(cro + xx * (sc + 1));
                pm = wrap10(cio + yy * (sc + 1));
                b.ctr  = jul ? ref_iter(wrap10(jcr), wrap10(jci), pr, pm, mx) : ref_iter(pr, pm, 0, 0, mx);
                b.x    = xx;
                b.y    = yy;
                b.eol  = (xx == ew - 1);
                b.last = (xx == ew - 1) && (yy == eh - 1);
                exq.push_back(b);
            end
        end
        n = exq.size();
        budget = n * (mx + 2) * 8 + 50;
        set_cfg(w, h, mx, sc, cro, cio, jul, jcr, jci);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        scramble_cfg();
        got = 0; held = 1'b0;
        h_ctr = '0; h_x = '0; h_y = '0; h_eol = 1'b0; h_last = 1'b0;
        for (int cyc = 0; cyc < budget && got < n; cyc++) begin
            pix_ready = ($urandom_range(0, 99) < ready_pct);
            #1;
            if (held) begin
                checks++;
                if (pix_valid !== 1'b1 || pix_ctr !== h_ctr || pix_x !== h_x || pix_y !== h_y ||
                    pix_eol !== h_eol || pix_last !== h_last) begin
                    errors++; $display("FAIL %s hold: beat changed while stalled (x=%0d y=%0d ctr=%0d, held x=%0d y=%0d ctr=%0d)",
                                       name, pix_x, pix_y, pix_ctr, h_x, h_y, h_ctr);
                end
            end
            held = (pix_valid === 1'b1) && !pix_ready;
            h_ctr = pix_ctr; h_x = pix_x; h_y = pix_y; h_eol = pix_eol; h_last = pix_last;
            b = exq[got];
            checks++;
            if (frame_done !== ((pix_valid === 1'b1) && pix_ready && b.last)) begin
                errors++; $display("FAIL %s frame_done: got %b at beat %0d", name, frame_done, got);
            end
            if (pix_valid === 1'b1 && pix_ready) begin
                checks++;
                if (pix_ctr !== CW'(b.ctr) || pix_x !== XW'(b.x) || pix_y !== YW'(b.y) ||
                    pix_eol !== b.eol || pix_last !== b.last) begin
                    errors++;
                    $display("FAIL %s beat%0d: got ctr=%0d x=%0d y=%0d eol=%b last=%b want ctr=%0d x=%0d y=%0d eol=%b last=%b",
                             name, got, pix_ctr, pix_x, pix_y, pix_eol, pix_last, b.ctr, b.x, b.y, b.eol, b.last);
                end
                got++;
            end
            @(negedge clk);
        end
        checks++; if (got != n) begin errors++; $display("FAIL %s beats: got %0d want %0d", name, got, n); end
        #1;
        checks++; if (busy !== 1'b0 || pix_valid !== 1'b0) begin
            errors++; $display("FAIL %s end: busy=%b valid=%b want 0 0", name, busy, pix_valid);
        end
        @(negedge clk);
        pix_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int xs[$];
        bit lasts[$];
        set_cfg(3, 1, 0, 0, 0, 0, 1'b0, 0, 0);
        pix_ready = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (pix_valid !== 1'b1 || pix_x !== '0 || pix_y !== '0 || pix_ctr !== '0 || pix_eol !== 1'b0 ||
                busy !== 1'b1 || frame_done !== 1'b0) begin
                errors++; $display("FAIL bp stall%0d: valid=%b x=%0d ctr=%0d eol=%b busy=%b done=%b want 1 0 0 0 1 0",
                                   i, pix_valid, pix_x, pix_ctr, pix_eol, busy, frame_done);
            end
            @(negedge clk);
        end
        pix_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (pix_valid === 1'b1) begin
                xs.push_back(int'(pix_x));
                lasts.push_back(pix_last);
            end
            @(negedge clk);
        end
        pix_ready = 1'b0;
        checks++; if (xs.size() != 3) begin errors++; $display("FAIL bp count: got %0d want 3", xs.size()); end
        for (int i = 0; i < 3 && i < xs.size(); i++) begin
            checks++;
            if (xs[i] != i || lasts[i] != (i == 2)) begin
                errors++; $display("FAIL bp order%0d: got x=%0d last=%b want x=%0d last=%b", i, xs[i], lasts[i], i, i == 2);
            end
        end
    endtask

    task automatic test_abort();
        int dones;
        set_cfg(4, 4, 3, 0, 0, 0, 1'b0, 0, 0);
        pix_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dones = 0;
        for (int i = 0; i < 4; i++) begin
            if (frame_done === 1'b1) dones++;
            @(negedge clk);
        end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort pre: busy=%b want 1", busy); end
        abort = 1'b1;
        start = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        checks++; if (busy !== 1'b0 || pix_valid !== 1'b0) begin
            errors++; $display("FAIL abort next: busy=%b valid=%b want 0 0", busy, pix_valid);
        end
        for (int i = 0; i < 10; i++) begin
            if (frame_done === 1'b1 || pix_valid === 1'b1 || busy === 1'b1) dones++;
            @(negedge clk);
        end
        checks++; if (dones != 0) begin errors++; $display("FAIL abort quiet: got %0d stray events want 0", dones); end
        run_frame("after_abort", 4, 4, 3, 5, -100, 40, 1'b0, 0, 0, 70);
    endtask

    task automatic test_reset_mid();
        int stray;
        set_cfg(4, 4, 5, 0, 0, 0, 1'b0, 0, 0);
        pix_ready = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        checks++; if (pix_valid !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL rst_mid pre: valid=%b busy=%b want 1 1", pix_valid, busy);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || pix_valid !== 1'b0 || frame_done !== 1'b0 || pix_ctr !== '0 ||
            pix_x !== '0 || pix_y !== '0 || pix_eol !== 1'b0 || pix_last !== 1'b0) begin
            errors++; $display("FAIL rst_mid async: busy=%b valid=%b done=%b ctr=%0d x=%0d y=%0d eol=%b last=%b want all 0",
                               busy, pix_valid, frame_done, pix_ctr, pix_x, pix_y, pix_eol, pix_last);
        end
        @(negedge clk);
        rst = 1'b0;
        pix_ready = 1'b1;
        stray = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (pix_valid !== 1'b0 || busy !== 1'b0) stray++;
            @(negedge clk);
        end
        checks++; if (stray != 0) begin errors++; $display("FAIL rst_mid quiet: got %0d stray cycles want 0", stray); end
        pix_ready = 1'b0;
    endtask

    task automatic test_random_frames();
        for (int t = 0; t < 6; t++) begin
            run_frame($sformatf("rand%0d", t), $urandom_range(0, 5), $urandom_range(0, 4),
                      $urandom_range(0, 12), $urandom_range(0, 127),
                      int'($urandom_range(0, 1023)) - 512, int'($urandom_range(0, 1023)) - 512,
                      1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 511)) - 256, int'($urandom_range(0, 511)) - 256,
                      $urandom_range(30, 100));
        end
    endtask

    initial begin
        test_reset();
        test_small_frame();
        test_center();
        test_escape();
        test_overflow();
        test_backpressure();
        test_abort();
        test_reset_mid();
        test_random_frames();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mandelbrot_stream.md
MANDELBROT_STREAM -- requirements
Module: mandelbrot_stream

Interface
REQ-001 SHALL have parameter BITWIDTH, default 10, meaning signed fixed-point width of z and c.
REQ-002 SHALL have parameter FRAC, default BITWIDTH-3, meaning fractional bits, so 1.0 = 1<<FRAC.
REQ-003 SHALL have parameter CTRWIDTH, default 8, meaning iteration counter width.
REQ-004 SHALL have parameter MAXW, default 320, meaning the maximum image width; XW = $clog2(MAXW+1).
REQ-005 SHALL have parameter MAXH, default 240, meaning the maximum image height; YW = $clog2(MAXH+1).
REQ-006 SHALL have one clock; reset is asynchronous and active-high: clk input 1, rising-edge clock.
REQ-007 SHALL have rst, input, 1 bit: asynchronous active-high reset.
REQ-008 SHALL have start, input, 1 bit: frame start request, sampled only in IDLE.
REQ-009 SHALL have abort, input, 1 bit: cancel the frame in progress.
REQ-010 SHALL have julia, input, 1 bit: 0 selects Mandelbrot, 1 selects Julia.
REQ-011 SHALL have cfg_width (input, XW bits) and cfg_height (input, YW bits): image size in pixels, where 0 is treated as 1.
REQ-012 SHALL have max_ctr, input, CTRWIDTH bits: iteration limit.
REQ-013 SHALL have scaling, input, 7 bits: pixel step = scaling+1 LSBs.
REQ-014 SHALL have cr_offset and ci_offset, inputs, BITWIDTH bits: coordinate of pixel (0,0).
REQ-015 SHALL have julia_cr and julia_ci, inputs, BITWIDTH bits: Julia constant c.
REQ-016 SHALL have busy, output, 1 bit: frame generation active.
REQ-017 SHALL have pix_valid (output, 1) and pix_ready (input, 1): pixel stream handshake.
REQ-018 SHALL have pix_ctr (output, CTRWIDTH), pix_x (output, XW), and pix_y (output, YW): pixel result and position.
REQ-019 SHALL have pix_eol (output, 1): last pixel of line; and pix_last (output, 1): last pixel of frame.
REQ-020 SHALL have frame_done, output, 1 bit: one-cycle pulse when the pix_last beat is accepted.

Function
REQ-021 SHALL implement states IDLE and ITER.
REQ-022 IDLE: on start=1, the block SHALL latch all cfg/offset/scaling/julia/max_ctr inputs, set x=y=0, load the first pixel, and enter ITER the next cycle; input changes during ITER SHALL be ignored.
REQ-023 Pixel load: the pixel coordinate SHALL be p = (cr_offset + x*(scaling+1), ci_offset + y*(scaling+1)), formed incrementally with modulo-2^BITWIDTH wrap.
REQ-024 Pixel load, Mandelbrot mode: the block SHALL set z=0 and c=p.
REQ-025 Pixel load, Julia mode: the block SHALL set z=p and c=julia constant.
REQ-026 Pixel load: the block SHALL clear ctr and the overflow flag.
REQ-027 Each ITER cycle SHALL evaluate break = (zr²+zi² ≥ 4.0) OR (ctr == max_ctr) OR overflow flag, using the current z.
REQ-028 If break=0, the block SHALL update zr ← ((zr²−zi²)>>>FRAC)+cr and zi ← ((2·zr·zi)>>>FRAC)+ci, set ctr+1, and set overflow flag = (either full-precision result not representable in BITWIDTH signed).
REQ-029 Intermediate products SHALL be at least 2·BITWIDTH+2 bits wide; on overflow the truncated z is stored and the flag forces a break on the next cycle.
REQ-030 If break=1 and the output slot is free (pix_valid=0 or pix_ready=1), the block SHALL load pix_ctr=ctr, pix_x, pix_y, pix_eol, and pix_last, set pix_valid=1, and advance to the next pixel in the same cycle.
REQ-031 If break=1 and the output slot is full, the block SHALL hold all state (stall) until the slot is free.
REQ-032 Advance: if x==width−1, the block SHALL set x=0 and y+1 and reload the row start; otherwise it SHALL set x+1.
REQ-033 When the last pixel is loaded into the output slot, the block SHALL go to IDLE and busy SHALL drop the next cycle.
REQ-034 Latency: a pixel whose result is k SHALL take k+1 ITER cycles, and pix_valid SHALL rise on the cycle after the break cycle.
REQ-035 pix_valid SHALL clear on the handshake (pix_valid & pix_ready) unless reloaded in the same cycle; outputs SHALL be stable while pix_valid=1 and pix_ready=0.
REQ-036 busy SHALL be 1 exactly when the state is ITER.
REQ-037 abort in ITER SHALL cause: state→IDLE, pix_valid→0, and no frame_done; abort in IDLE SHALL be ignored.
REQ-038 abort and start in the same cycle SHALL behave as abort.
REQ-039 start while busy SHALL be ignored.
REQ-040 A pending final pixel SHALL remain valid in IDLE until accepted; start in IDLE while pix_valid=1 SHALL be accepted, and the new frame SHALL stall on its first break until the slot frees.

Reset
REQ-041 rst=1 SHALL asynchronously force IDLE with busy=0, pix_valid=0, frame_done=0, and pix_ctr=pix_x=pix_y=0.
REQ-042 rst=1 SHALL asynchronously force pix_eol=pix_last=0, x=y=0, ctr=0, and z=c=0.
REQ-043 rst asserted mid-frame SHALL discard the frame with no further output beats.

Verification
REQ-044 Bench SHALL cover: width=2, height=2, max_ctr=0, pix_ready=1 → 4 beats on consecutive cycles starting 2 cycles after start, (x,y) = (0,0),(1,0),(0,1),(1,1), eol on beats 2 and 4, last and frame_done on beat 4.
REQ-045 Bench SHALL cover: Mandelbrot, width=height=1, c=(0,0), max_ctr=20 → pix_ctr=20 after 21 ITER cycles.
REQ-046 Bench SHALL cover: Mandelbrot, c=(2.0,0)=(256,0) with BITWIDTH=10, max_ctr=50 → pix_ctr=1; Julia, z0=(2.0,0) → pix_ctr=0.
REQ-047 Bench SHALL cover: pix_ready=0 for 10 cycles on a 3-pixel frame with max_ctr=0 → first beat held stable, engine stalls, and no pixel is lost or duplicated.
REQ-048 Bench SHALL cover: abort 5 cycles into a 4x4 frame → busy=0 and pix_valid=0 next cycle, no frame_done, and a following start produces a complete frame from (0,0).
REQ-049 Bench SHALL cover: rst pulse mid-frame and an overflow case (c=(3.9,3.9)) → rst clears all outputs asynchronously; overflow pixel breaks at ctr≤2 with no X propagation.
